fib_seq_ctrl: RTL and testbench
===============================

Name: fib_seq_ctrl

Overview:
Parametrised control FSM that sequences the register-file/ALU datapath to generate a Fibonacci-style series into consecutive registers R1..R(NUM_REGS-1).
- Replaces the fixed 5-step free-running sequencer.
- Adds programmable seeds, a programmable term count, a start/busy/done handshake, and clamping at the register-file bound.
- Sits beside the register file, ALU and immediate mux. It drives their selects and enables; it never touches data.

Parameters:
NUM_REGS, 16, registers in the file; R0 is reserved as constant zero and is never written.
SEL_W, 5, width of the muxA/muxB register selects.
DATA_W, 16, width of the immediate and seed values.
OP_W, 8, width of alu_op.
ADD_OP, 8'h05, ALU opcode for add.
CNT_W, 8, width of num_terms and term_idx.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a sequence; sampled only in IDLE or DONE
seed0  in  DATA_W  first term; written to R1
seed1  in  DATA_W  second term; written to R2
num_terms  in  CNT_W  total terms to write, seeds included
busy  out  1  high in LOAD0, LOAD1, RUN
done  out  1  high in DONE; sticky until the next accepted start
term_idx  out  CNT_W  index of the term being written this cycle (0-based)
alu_op  out  OP_W  ALU opcode
muxA  out  SEL_W  ALU operand A register select
muxB  out  SEL_W  ALU operand B register select
regs_en  out  NUM_REGS  one-hot register write enable
imm  out  DATA_W  immediate value
imm_control  out  1  1 = ALU operand B comes from imm
buff_en  out  1  display/tri-state buffer enable

Behaviour:
- Interface: one clock `clk`. `reset` is asynchronous and active-high. All outputs are registered flops, so no combinational path from inputs to outputs.
- Reset values: state=IDLE, busy=0, done=0, term_idx=0, alu_op=0, muxA=0, muxB=0, regs_en=0, imm=0, imm_control=0, buff_en=1.
- Reset asserted mid-sequence aborts immediately to these values; no further write enables are issued.
- Effective count: eff = min(num_terms, NUM_REGS-1). num_terms and seeds are latched when start is accepted; later input changes are ignored until DONE.
- States and transitions:
  - IDLE: start=1 -> LOAD0 if eff>=1, else -> DONE (no writes).
  - LOAD0: alu_op=ADD_OP, muxA=0, imm=seed0, imm_control=1, regs_en=1<<1, term_idx=0. Next: eff==1 -> DONE, else -> LOAD1.
  - LOAD1: same as LOAD0 but imm=seed1, regs_en=1<<2, term_idx=1. Next: eff==2 -> DONE, else -> RUN.
  - RUN, term t>=2: alu_op=ADD_OP, muxA=t-1, muxB=t, imm=0, imm_control=0, regs_en=1<<(t+1), term_idx=t. t increments each cycle. Leave to DONE after t==eff-1.
  - DONE: regs_en=0, alu_op=0, imm_control=0, done=1. start=1 -> LOAD0 (or DONE again if eff=0), and done drops in the same edge.
- Timing: start accepted at edge k; the first write enable is visible after edge k, and term t's enable is visible after edge k+t. done rises after edge k+eff.
- Exactly one regs_en bit is ever high; bit 0 is never set.
- start while busy is ignored.
- buff_en stays 1 in all states.

Optional Feature:
FIB_WRAP_EN
- Defined: eff = num_terms with no clamp. The write index cycles through R1..R(NUM_REGS-1) as a ring; after R(NUM_REGS-1), the next write goes to R1. muxA/muxB are always the previous two write indices (with wrap), so term 15 (NUM_REGS=16) uses muxA=R14, muxB=R15 and writes R1.
- Undefined: clamp to NUM_REGS-1 as above.

Decomposition:
- Package fib_seq_pkg holds:
  - state enum: IDLE, LOAD0, LOAD1, RUN, DONE
  - ADD_OP default
  - helper function for one-hot decode of a register index
- One natural sub-module, fib_idx_ring: holds current, previous and previous-previous write indices. It handles increment/wrap and provides the muxA/muxB/write-index triple. Under FIB_WRAP_EN it wraps; otherwise it saturates.

Test Plan:
- Reset during RUN (num_terms=10, assert reset at t=4) -> all outputs immediately return to reset values; regs_en=0 thereafter; next start restarts cleanly at LOAD0.
- seed0=0, seed1=1, num_terms=6, start pulse:
  - regs_en sequence 0x0002, 0x0004, 0x0008, 0x0010, 0x0020, 0x0040.
  - imm_control 1,1,0,0,0,0; (muxA,muxB) for RUN = (1,2), (2,3), (3,4), (4,5).
  - Model datapath yields R1..R6 = 0,1,1,2,3,5; done rises 6 cycles after start.
- num_terms=0 -> no regs_en pulse, DONE one cycle after start. num_terms=1 -> single write to R1 with imm=seed0. num_terms=2 -> R1, R2 only.
- num_terms=40 without FIB_WRAP_EN, NUM_REGS=16 -> 15 writes (R1..R15), last write regs_en=0x8000, done after 15 cycles, R15=377 for seeds 0,1.
- With FIB_WRAP_EN, num_terms=17 -> write 16 goes to R1 with (muxA,muxB)=(14,15), write 17 goes to R2 with (15,1).
- start held high during busy, and new seeds applied mid-run -> sequence unaffected. In DONE, start with seed0=2, seed1=3, num_terms=4 -> done drops; R1..R4 = 2,3,5,8.

Source files
------------

// File: rtl/fib_seq_pkg.sv
// Purpose: shared types and helpers for the Fibonacci sequencer (state codes, ALU add opcode, one-hot decode).
// Latency: none; declarations and pure functions only.
// Backpressure: not applicable.
package fib_seq_pkg;

    // Sequencer state codes; the top mirrors these as plain localparam constants.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD0 = 3'd1,
        S_LOAD1 = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } fib_state_e;

    // Default ALU opcode for add.
    localparam logic [7:0] ADD_OP_DEF = 8'h05;

    // Widest register file the one-hot helper can decode; callers truncate to their own size.
    localparam int FIB_MAX_REGS = 64;

    // One-hot write enable for register idx. R0 is the constant-zero register and
    // never gets an enable, so idx 0 (and anything out of range) decodes to all-zero.
    function automatic logic [FIB_MAX_REGS-1:0] reg_onehot(input int unsigned idx);
        logic [FIB_MAX_REGS-1:0] v;
        v = '0;
        if (idx != 0 && idx < FIB_MAX_REGS) begin
            v = FIB_MAX_REGS'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/fib_seq_ctrl_idx_ring.sv
// Purpose: tracks the last two register indices written and offers the next write index plus ALU operand selects.
// Latency: outputs are a combinational view of two index flops; init/adv take effect on the next clk edge.
// Backpressure: none; the controller pulses adv once per issued write.
// Build option FIB_WRAP_EN: next index wraps R(NUM_REGS-1) -> R1; otherwise it saturates at R(NUM_REGS-1).
module fib_idx_ring
    import fib_seq_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             adv,
    output logic [SEL_W-1:0] wr_idx,
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b
);

    localparam logic [SEL_W-1:0] TOP_IDX = SEL_W'(NUM_REGS - 1);
    localparam logic [SEL_W-1:0] ONE_IDX = SEL_W'(1);

    // last_q is the most recent write index, prev_q the one before it.
    logic [SEL_W-1:0] last_q;
    logic [SEL_W-1:0] prev_q;
    logic [SEL_W-1:0] next_idx;

    // Successor of the last write index: wrap back to R1 or hold at the top register.
    always_comb begin
        next_idx = last_q + ONE_IDX;
`ifdef FIB_WRAP_EN
        if (last_q == TOP_IDX) begin
            next_idx = ONE_IDX;
        end
`else
        if (last_q == TOP_IDX) begin
            next_idx = TOP_IDX;
        end
`endif
    end

    // init records the seed write to R1 that the controller issues itself; adv shifts history by one write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= '0;
            prev_q <= '0;
        end else if (init) begin
            last_q <= ONE_IDX;
            prev_q <= '0;
        end else if (adv) begin
            prev_q <= last_q;
            last_q <= next_idx;
        end
    end

    // The upcoming write sums the two most recently written registers.
    assign wr_idx = next_idx;
    assign sel_a  = prev_q;
    assign sel_b  = last_q;

endmodule

// File: rtl/fib_seq_ctrl.sv
// Purpose: control FSM driving register-file/ALU selects and enables to write a Fibonacci series into R1..R(NUM_REGS-1).
// Latency: start accepted at edge k -> term t enable visible after edge k+t; done after edge k+eff; all outputs registered.
// Backpressure: start ignored while busy; done is sticky until the next accepted start. Build option FIB_WRAP_EN removes the clamp and wraps writes.
module fib_seq_ctrl
    import fib_seq_pkg::*;
#(
    parameter int              NUM_REGS = 16,
    parameter int              SEL_W    = 5,
    parameter int              DATA_W   = 16,
    parameter int              OP_W     = 8,
    parameter logic [OP_W-1:0] ADD_OP   = OP_W'(ADD_OP_DEF),
    parameter int              CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_W-1:0]   seed0,
    input  logic [DATA_W-1:0]   seed1,
    input  logic [CNT_W-1:0]    num_terms,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    term_idx,
    output logic [OP_W-1:0]     alu_op,
    output logic [SEL_W-1:0]    muxA,
    output logic [SEL_W-1:0]    muxB,
    output logic [NUM_REGS-1:0] regs_en,
    output logic [DATA_W-1:0]   imm,
    output logic                imm_control,
    output logic                buff_en
);

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_LOAD0 = S_LOAD0;
    localparam logic [2:0] ST_LOAD1 = S_LOAD1;
    localparam logic [2:0] ST_RUN   = S_RUN;
    localparam logic [2:0] ST_DONE  = S_DONE;

    // Largest term count that fits R1..R(NUM_REGS-1) without reuse.
    localparam logic [CNT_W-1:0] MAX_TERMS = CNT_W'(NUM_REGS - 1);

    logic [2:0]        state;
    logic [DATA_W-1:0] seed1_q;
    logic [CNT_W-1:0]  eff_q;
    logic [CNT_W-1:0]  eff_in;
    logic [CNT_W-1:0]  term_inc;
    logic              in_seq;
    logic              accept;
    logic              last_term;
    logic              ring_init;
    logic              ring_adv;
    logic [SEL_W-1:0]  ring_wr;
    logic [SEL_W-1:0]  ring_a;
    logic [SEL_W-1:0]  ring_b;

    // Effective number of terms for a start presented this cycle.
    always_comb begin
`ifdef FIB_WRAP_EN
        eff_in = num_terms;
`else
        eff_in = (num_terms > MAX_TERMS) ? MAX_TERMS : num_terms;
`endif
    end

    assign in_seq    = (state == ST_LOAD0) || (state == ST_LOAD1) || (state == ST_RUN);
    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign term_inc  = term_idx + CNT_W'(1);
    // The term currently on the outputs is the final one of the sequence.
    assign last_term = (term_inc == eff_q);
    // The seed write to R1 seeds the index history; each further write advances it.
    assign ring_init = accept && (eff_in != '0);
    assign ring_adv  = in_seq && !last_term;

    fib_idx_ring #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_ring (
        .clk    (clk),
        .reset  (reset),
        .init   (ring_init),
        .adv    (ring_adv),
        .wr_idx (ring_wr),
        .sel_a  (ring_a),
        .sel_b  (ring_b)
    );

    // State and registered datapath controls: each edge loads the controls for the write in the coming cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            term_idx    <= '0;
            alu_op      <= '0;
            muxA        <= '0;
            muxB        <= '0;
            regs_en     <= '0;
            imm         <= '0;
            imm_control <= 1'b0;
            buff_en     <= 1'b1;
            seed1_q     <= '0;
            eff_q       <= '0;
        end else begin
            buff_en <= 1'b1;
            if (accept) begin
                // Inputs are captured once here; later changes cannot disturb the run.
                seed1_q <= seed1;
                eff_q   <= eff_in;
                if (eff_in != '0) begin
                    state       <= ST_LOAD0;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    term_idx    <= '0;
                    alu_op      <= ADD_OP;
                    muxA        <= '0;
                    muxB        <= '0;
                    imm         <= seed0;
                    imm_control <= 1'b1;
                    regs_en     <= NUM_REGS'(reg_onehot(1));
                end else begin
                    // Nothing to write: report completion straight away.
                    state       <= ST_DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    alu_op      <= '0;
                    muxA        <= '0;
                    muxB        <= '0;
                    imm         <= '0;
                    imm_control <= 1'b0;
                    regs_en     <= '0;
                end
            end else if (in_seq) begin
                if (last_term) begin
                    state       <= ST_DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    alu_op      <= '0;
                    muxA        <= '0;
                    muxB        <= '0;
                    imm         <= '0;
                    imm_control <= 1'b0;
                    regs_en     <= '0;
                end else begin
                    term_idx <= term_inc;
                    alu_op   <= ADD_OP;
                    regs_en  <= NUM_REGS'(reg_onehot(32'(ring_wr)));
                    if (state == ST_LOAD0) begin
                        // Second seed: R0 + imm, same shape as the first load.
                        state       <= ST_LOAD1;
                        muxA        <= '0;
                        muxB        <= '0;
                        imm         <= seed1_q;
                        imm_control <= 1'b1;
                    end else begin
                        // Recurrence: sum of the two previously written registers.
                        state       <= ST_RUN;
                        muxA        <= ring_a;
                        muxB        <= ring_b;
                        imm         <= '0;
                        imm_control <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
module tb_fib_seq_ctrl;

    localparam int NUM_REGS = 16;
    localparam int SEL_W    = 5;
    localparam int DATA_W   = 16;
    localparam int OP_W     = 8;
    localparam int CNT_W    = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       seed0 = '0;
    logic [15:0]       seed1 = '0;
    logic [7:0]        num_terms = '0;
    logic              busy, done, imm_control, buff_en;
    logic [7:0]        term_idx, alu_op;
    logic [4:0]        muxA, muxB;
    logic [15:0]       regs_en, imm;

    fib_seq_ctrl #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W),
        .DATA_W   (DATA_W),
        .OP_W     (OP_W),
        .ADD_OP   (8'h05),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .seed0       (seed0),
        .seed1       (seed1),
        .num_terms   (num_terms),
        .busy        (busy),
        .done        (done),
        .term_idx    (term_idx),
        .alu_op      (alu_op),
        .muxA        (muxA),
        .muxB        (muxB),
        .regs_en     (regs_en),
        .imm         (imm),
        .imm_control (imm_control),
        .buff_en     (buff_en)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [15:0] en;
        logic [4:0]  ma;
        logic [4:0]  mb;
        logic [15:0] imm;
        logic        ic;
        logic [7:0]  term;
        bit          run;
    } wr_t;

    wr_t pend[$];
    wr_t cur;
    bit  m_busy = 0;
    bit  m_done = 0;
    bit  cmp_en = 0;
    logic [15:0] rf [0:15];

    function automatic int eff_of(input int n);
`ifdef FIB_WRAP_EN
        return n;
`else
        return (n < NUM_REGS - 1) ? n : NUM_REGS - 1;
`endif
    endfunction

    // Register written by term t: R1..R15 used as a ring (never wraps when clamped).
    function automatic int widx(input int t);
        return (t % (NUM_REGS - 1)) + 1;
    endfunction

    // Model: on an accepted start, list every write the sequence must make; emit one per cycle.
    initial begin : model
        int  e;
        wr_t w;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_busy = 0;
                m_done = 0;
                pend.delete();
            end else if (m_busy) begin
                if (pend.size() > 0) cur = pend.pop_front();
                else begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (start) begin
                e = eff_of(int'(num_terms));
                for (int t = 0; t < e; t++) begin
                    w.en   = 16'(1) << widx(t);
                    w.term = 8'(t);
                    if (t < 2) begin
                        w.ic = 1'b1; w.imm = (t == 0) ? seed0 : seed1;
                        w.ma = '0; w.mb = '0; w.run = 0;
                    end else begin
                        w.ic = 1'b0; w.imm = '0;
                        w.ma = 5'(widx(t - 2)); w.mb = 5'(widx(t - 1)); w.run = 1;
                    end
                    pend.push_back(w);
                end
                if (e == 0) m_done = 1;
                else begin
                    cur = pend.pop_front();
                    m_busy = 1;
                    m_done = 0;
                end
            end
        end
    end

    // Compare every cycle, then apply the DUT's write to a model register file/ALU.
    initial begin : cmp
        int wi;
        for (int r = 0; r < 16; r++) rf[r] = '0;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("busy", 32'(busy), 32'(m_busy));
                chk("done", 32'(done), 32'(m_done));
                chk("buff_en", 32'(buff_en), 1);
                chk("regs_en", 32'(regs_en), m_busy ? 32'(cur.en) : 0);
                chk("alu_op", 32'(alu_op), m_busy ? 32'h05 : 0);
                chk("imm_control", 32'(imm_control), m_busy ? 32'(cur.ic) : 0);
                if (m_busy) begin
                    chk("term_idx", 32'(term_idx), 32'(cur.term));
                    chk("muxA", 32'(muxA), 32'(cur.ma));
                    chk("imm", 32'(imm), 32'(cur.imm));
                    if (cur.run) chk("muxB", 32'(muxB), 32'(cur.mb));
                end
            end
            if (regs_en != '0) begin
                wi = 0;
                for (int i = 0; i < 16; i++) if (regs_en[i]) wi = i;
                rf[wi] = rf[muxA[3:0]] + (imm_control ? imm : rf[muxB[3:0]]);
            end
        end
    end

    // Independent expectation for the register file: plain Fibonacci from the seeds.
    task automatic check_rf(input string tag, input logic [15:0] s0, input logic [15:0] s1, input int n);
        logic [15:0] f [0:255];
        logic [15:0] exp_rf [0:15];
        bit          wr [0:15];
        int          e;
        e = eff_of(n);
        for (int r = 0; r < 16; r++) begin exp_rf[r] = '0; wr[r] = 0; end
        for (int t = 0; t < e; t++) begin
            f[t] = (t == 0) ? s0 : (t == 1) ? s1 : f[t-1] + f[t-2];
            exp_rf[widx(t)] = f[t];
            wr[widx(t)] = 1;
        end
        for (int r = 1; r < 16; r++)
            if (wr[r]) chk($sformatf("%s_R%0d", tag, r), 32'(rf[r]), 32'(exp_rf[r]));
    endtask

    // ---------------- directed/random drivers ----------------
    logic [15:0] log_en  [0:255];
    logic [15:0] log_imm [0:255];
    logic [4:0]  log_ma  [0:255];
    logic [4:0]  log_mb  [0:255];
    logic        log_ic  [0:255];
    int          nlog, ncyc;
    bit          seen_done, first_done;

    task automatic run_seq(input logic [15:0] s0, input logic [15:0] s1, input logic [7:0] n, input bit hold);
        @(posedge clk); #2;
        seed0 = s0; seed1 = s1; num_terms = n; start = 1'b1;
        @(posedge clk); #2;
        if (!hold) start = 1'b0;
        ncyc = 0; nlog = 0; seen_done = 0; first_done = 0;
        while (!seen_done && ncyc < 400) begin
            @(negedge clk);
            ncyc++;
            if (ncyc == 1) first_done = done;
            if (regs_en != '0 && nlog < 256) begin
                log_en[nlog] = regs_en; log_imm[nlog] = imm;
                log_ma[nlog] = muxA;    log_mb[nlog] = muxB; log_ic[nlog] = imm_control;
                nlog++;
            end
            if (hold && ncyc == 2) begin
                seed0 = 16'hdead; seed1 = 16'hbeef; num_terms = 8'd3;
            end
            if (done) seen_done = 1;
        end
        start = 1'b0;
        chk("seq_reaches_done", 32'(seen_done), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_term_idx"}, 32'(term_idx), 0);
        chk({tag, "_alu_op"}, 32'(alu_op), 0);
        chk({tag, "_muxA"}, 32'(muxA), 0);
        chk({tag, "_muxB"}, 32'(muxB), 0);
        chk({tag, "_regs_en"}, 32'(regs_en), 0);
        chk({tag, "_imm"}, 32'(imm), 0);
        chk({tag, "_imm_control"}, 32'(imm_control), 0);
        chk({tag, "_buff_en"}, 32'(buff_en), 1);
    endtask

    task automatic reset_mid(input logic [7:0] n, input int at, input string tag);
        @(posedge clk); #2;
        seed0 = 16'd0; seed1 = 16'd1; num_terms = n; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (at) @(negedge clk);
        #1 reset = 1'b1;
        #1 chk_reset_vals(tag);
        repeat (2) begin
            @(negedge clk);
            chk({tag, "_en_in_reset"}, 32'(regs_en), 0);
        end
        @(posedge clk); #2 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_en_after"}, 32'(regs_en), 0);
            chk({tag, "_busy_after"}, 32'(busy), 0);
        end
    endtask

    // Hand-computed expectations for seeds 0,1 and six terms.
    logic [15:0] e_en6 [0:5] = '{16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040};
    logic        e_ic6 [0:5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [4:0]  e_ma6 [0:5] = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
    logic [4:0]  e_mb6 [0:5] = '{5'd0, 5'd0, 5'd2, 5'd3, 5'd4, 5'd5};
    logic [15:0] e_rf6 [0:5] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5};
    logic [15:0] e_rf8 [0:7] = '{16'd5, 16'd7, 16'd12, 16'd19, 16'd31, 16'd50, 16'd81, 16'd131};
    logic [15:0] e_rf4 [0:3] = '{16'd2, 16'd3, 16'd5, 16'd8};

    initial begin : main
        logic [15:0] rs0, rs1;
        logic [7:0]  rn;
        #1 reset = 1'b1;
        #1 cmp_en = 1;
        #20 chk_reset_vals("por");
        @(posedge clk); #2 reset = 1'b0;

        // Basic six-term run.
        run_seq(16'd0, 16'd1, 8'd6, 0);
        chk("n6_nwrites", nlog, 6);
        chk("n6_done_lat", ncyc - 1, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("n6_en%0d", i), 32'(log_en[i]), 32'(e_en6[i]));
            chk($sformatf("n6_ic%0d", i), 32'(log_ic[i]), 32'(e_ic6[i]));
            chk($sformatf("n6_ma%0d", i), 32'(log_ma[i]), 32'(e_ma6[i]));
            if (i >= 2) chk($sformatf("n6_mb%0d", i), 32'(log_mb[i]), 32'(e_mb6[i]));
            chk($sformatf("n6_R%0d", i + 1), 32'(rf[i+1]), 32'(e_rf6[i]));
        end
        check_rf("n6", 16'd0, 16'd1, 6);

        // Zero, one and two terms.
        run_seq(16'd7, 16'd9, 8'd0, 0);
        chk("n0_nwrites", nlog, 0);
        chk("n0_done_lat", ncyc - 1, 0);
        run_seq(16'h1234, 16'h5678, 8'd1, 0);
        chk("n1_nwrites", nlog, 1);
        chk("n1_en", 32'(log_en[0]), 32'h0002);
        chk("n1_imm", 32'(log_imm[0]), 32'h1234);
        chk("n1_done_lat", ncyc - 1, 1);
        chk("n1_R1", 32'(rf[1]), 32'h1234);
        run_seq(16'd3, 16'd4, 8'd2, 0);
        chk("n2_nwrites", nlog, 2);
        chk("n2_en0", 32'(log_en[0]), 32'h0002);
        chk("n2_en1", 32'(log_en[1]), 32'h0004);
        chk("n2_done_lat", ncyc - 1, 2);

`ifndef FIB_WRAP_EN
        // Clamp at the register-file bound.
        run_seq(16'd0, 16'd1, 8'd40, 0);
        chk("n40_nwrites", nlog, 15);
        chk("n40_last_en", 32'(log_en[14]), 32'h8000);
        chk("n40_done_lat", ncyc - 1, 15);
        chk("n40_R15", 32'(rf[15]), 377);
`else
        // Ring wrap past R15.
        run_seq(16'd0, 16'd1, 8'd17, 0);
        chk("w17_nwrites", nlog, 17);
        chk("w17_en16", 32'(log_en[15]), 32'h0002);
        chk("w17_ma16", 32'(log_ma[15]), 14);
        chk("w17_mb16", 32'(log_mb[15]), 15);
        chk("w17_en17", 32'(log_en[16]), 32'h0004);
        chk("w17_ma17", 32'(log_ma[16]), 15);
        chk("w17_mb17", 32'(log_mb[16]), 1);
        check_rf("w17", 16'd0, 16'd1, 17);
`endif

        // Reset while term 4 is on the outputs, then a clean restart.
        reset_mid(8'd10, 5, "rst_run");
        run_seq(16'd1, 16'd1, 8'd3, 0);
        chk("restart_nwrites", nlog, 3);
        chk("restart_en0", 32'(log_en[0]), 32'h0002);
        check_rf("restart", 16'd1, 16'd1, 3);

        // start held and inputs changed mid-run; then restart from DONE.
        run_seq(16'd5, 16'd7, 8'd8, 1);
        chk("hold_nwrites", nlog, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("hold_R%0d", i + 1), 32'(rf[i+1]), 32'(e_rf8[i]));
        run_seq(16'd2, 16'd3, 8'd4, 0);
        chk("redo_done_drops", 32'(first_done), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("redo_R%0d", i + 1), 32'(rf[i+1]), 32'(e_rf4[i]));

        // Randomised sequences, occasional held start and mid-run resets.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                reset_mid(8'($urandom_range(3, 20)), $urandom_range(1, 8), "rnd_rst");
            end
            rs0 = 16'($urandom);
            rs1 = 16'($urandom);
            rn  = 8'($urandom_range(0, 24));
            run_seq(rs0, rs1, rn, $urandom_range(0, 3) == 0);
            chk("rnd_nwrites", nlog, eff_of(int'(rn)));
            check_rf("rnd", rs0, rs1, int'(rn));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
